// File: rtl/mae_behav_model.sv
// ---------------------------------------------------------------------------
// mae_behav_model
//
// Cycle-accurate behavioural model of the MAE DSP primitive: an 18x18 signed
// multiplier followed by a 40-bit post-adder / accumulator. One parameter set
// selects the behaviour of an efpga_mult* / efpga_macc* mapping variant.
//
// Datapath:
//   A/B (and C) input regs -> multiplier -> optional mult pipe reg
//   -> post-adder (C or P feedback) -> P reg
//
// Parameters:
//   REG_A, REG_B       1: A/B input register in path (the two must match)
//   REG_C              1: C input register in path
//   REG_P              1: P output register in path
//   MULT_HAS_REG       1: pipeline register after the multiplier
//   POST_ADDER_STATIC  0: P = M; 1: post-adder active
//   USE_FEEDBACK       1: accumulate P <= P + M (requires REG_P = 1)
//
// Ports:
//   CLK            clock, every register updates on the rising edge
//   ARST           asynchronous reset, active-high, clears every register
//   A, B           18-bit signed operands
//   A_EN/B_EN      operand register load enables
//   A_SRST_N/B_SRST_N  operand register synchronous clears, active-low
//   C              40-bit signed addend / accumulator load value
//   C_EN, C_SRST_N C register load enable / synchronous clear
//   CDIN_FDBK_SEL  1: add P feedback; 0: load C + M (restart accumulation)
//   P_EN, P_SRST_N P register and mult pipe register enable / sync clear
//   IN_VALID       operand pair on A/B is valid this cycle
//   P              40-bit signed result
//   OUT_VALID      IN_VALID delayed by the pipeline latency
//   OVF            one-cycle pulse when the value written to P overflowed
//
// Build option:
//   MAE_SATURATE_EN  defined: signed overflow clamps P to the 40-bit
//                    extremes and pulses OVF.
//                    undefined: results wrap modulo 2^40, OVF stays 0.
//
// Register priority for every register: ARST > SRST_N low > EN high > hold.
// ---------------------------------------------------------------------------
module mae_behav_model #(
    parameter int REG_A             = 1,
    parameter int REG_B             = 1,
    parameter int REG_C             = 0,
    parameter int REG_P             = 1,
    parameter int MULT_HAS_REG      = 0,
    parameter int POST_ADDER_STATIC = 0,
    parameter int USE_FEEDBACK      = 0
) (
    input  logic                CLK,
    input  logic                ARST,
    input  logic signed [17:0]  A,
    input  logic                A_EN,
    input  logic                A_SRST_N,
    input  logic signed [17:0]  B,
    input  logic                B_EN,
    input  logic                B_SRST_N,
    input  logic signed [39:0]  C,
    input  logic                C_EN,
    input  logic                C_SRST_N,
    input  logic                CDIN_FDBK_SEL,
    input  logic                P_EN,
    input  logic                P_SRST_N,
    input  logic                IN_VALID,
    output logic signed [39:0]  P,
    output logic                OUT_VALID,
    output logic                OVF
);

    localparam int DATA_W = 18;
    localparam int COEF_W = 18;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = 40;

    // Number of register stages between the operands and P.
    localparam int STAGES = ((REG_A != 0) ? 1 : 0)
                          + ((MULT_HAS_REG != 0) ? 1 : 0)
                          + ((REG_P != 0) ? 1 : 0);

    // Parameter sanity: feedback needs a P register to feed back from, and
    // A/B must share one pipeline depth so the product pairs them correctly.
    if ((USE_FEEDBACK != 0) && (REG_P == 0)) begin : g_err_feedback
        $error("mae_behav_model: USE_FEEDBACK=1 requires REG_P=1");
    end
    if ((REG_A != 0) != (REG_B != 0)) begin : g_err_regab
        $error("mae_behav_model: REG_A and REG_B must match");
    end

    // The exact 36-bit product always fits a 40-bit signed container.
    function automatic logic signed [ACC_W-1:0] sext_prod(
        input logic signed [PROD_W-1:0] prod
    );
        return {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    endfunction

`ifdef MAE_SATURATE_EN
    // Clamp a 41-bit sum into signed 40-bit range.
    function automatic logic signed [ACC_W-1:0] sat_acc(
        input logic signed [ACC_W:0] sum
    );
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) begin
                return {1'b1, {(ACC_W-1){1'b0}}};
            end
            return {1'b0, {(ACC_W-1){1'b1}}};
        end
        return sum[ACC_W-1:0];
    endfunction

    function automatic logic sum_ovf(input logic signed [ACC_W:0] sum);
        return sum[ACC_W] ^ sum[ACC_W-1];
    endfunction
`endif

    // ---- stage p0: input registers ----
    logic signed [DATA_W-1:0] a_p0;
    logic signed [COEF_W-1:0] b_p0;
    logic signed [ACC_W-1:0]  c_p0;

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            a_p0 <= '0;
        end else if (!A_SRST_N) begin
            a_p0 <= '0;
        end else if (A_EN) begin
            a_p0 <= A;
        end
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            b_p0 <= '0;
        end else if (!B_SRST_N) begin
            b_p0 <= '0;
        end else if (B_EN) begin
            b_p0 <= B;
        end
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            c_p0 <= '0;
        end else if (!C_SRST_N) begin
            c_p0 <= '0;
        end else if (C_EN) begin
            c_p0 <= C;
        end
    end

    logic signed [DATA_W-1:0] a_s;
    logic signed [COEF_W-1:0] b_s;
    logic signed [ACC_W-1:0]  c_s;

    assign a_s = (REG_A != 0) ? a_p0 : A;
    assign b_s = (REG_B != 0) ? b_p0 : B;
    assign c_s = (REG_C != 0) ? c_p0 : C;

    // ---- stage p1: multiplier and optional pipe register ----
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  m_comb;
    logic signed [ACC_W-1:0]  m_p1;
    logic signed [ACC_W-1:0]  m_s;

    assign prod   = a_s * b_s;
    assign m_comb = sext_prod(prod);

    // The mult pipe register shares the P enable/clear so a stalled P also
    // freezes the product feeding it.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            m_p1 <= '0;
        end else if (!P_SRST_N) begin
            m_p1 <= '0;
        end else if (P_EN) begin
            m_p1 <= m_comb;
        end
    end

    assign m_s = (MULT_HAS_REG != 0) ? m_p1 : m_comb;

    // ---- stage p2: post-adder and P register ----
    logic signed [ACC_W-1:0] p_p2;
    logic                    ovf_p2;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] s_val;
    logic                    ovf_comb;

    always_comb begin
        addend = '0;
        if (POST_ADDER_STATIC != 0) begin
            if ((USE_FEEDBACK != 0) && CDIN_FDBK_SEL) begin
                addend = p_p2;
            end else begin
                addend = c_s;
            end
        end
    end

`ifdef MAE_SATURATE_EN
    logic signed [ACC_W:0] sum_ext;

    // One guard bit exposes signed overflow of the 40-bit add.
    assign sum_ext  = {m_s[ACC_W-1], m_s} + {addend[ACC_W-1], addend};
    assign s_val    = sat_acc(sum_ext);
    assign ovf_comb = sum_ovf(sum_ext);
`else
    assign s_val    = m_s + addend;
    assign ovf_comb = 1'b0;
`endif

    // OVF is cleared whenever P does not take a new value, so it pulses for
    // exactly the cycle whose write overflowed.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            p_p2   <= '0;
            ovf_p2 <= 1'b0;
        end else if (!P_SRST_N) begin
            p_p2   <= '0;
            ovf_p2 <= 1'b0;
        end else if (P_EN) begin
            p_p2   <= s_val;
            ovf_p2 <= ovf_comb;
        end else begin
            ovf_p2 <= 1'b0;
        end
    end

    assign P   = (REG_P != 0) ? p_p2 : s_val;
    assign OVF = (REG_P != 0) ? ovf_p2 : ovf_comb;

    // ---- valid pipeline: free-running, independent of the enables ----
    if (STAGES == 0) begin : g_vld_comb
        assign OUT_VALID = IN_VALID;
    end else begin : g_vld_reg
        logic [STAGES-1:0] vld_p;

        always_ff @(posedge CLK or posedge ARST) begin
            if (ARST) begin
                vld_p <= '0;
            end else begin
                vld_p <= STAGES'({vld_p, IN_VALID});
            end
        end

        assign OUT_VALID = vld_p[STAGES-1];
    end

endmodule

// File: tb/tb_mae_behav_model.sv
// ---------------------------------------------------------------------------
// tb_mae_behav_model
//
// Directed bench for mae_behav_model. Four instances share the same stimulus
// and each scenario task checks the instance whose configuration it targets:
//   u_def : default parameters (REG_A/B/P, latency 2, P = M)
//   u_add : post-adder with registered C (P = M + C')
//   u_acc : accumulator (post-adder + feedback, C combinational)
//   u_mr  : default plus mult pipe register (latency 3)
// ---------------------------------------------------------------------------
module tb_mae_behav_model;

    logic               CLK = 1'b0;
    logic               ARST;
    logic signed [17:0] A, B;
    logic signed [39:0] C;
    logic               A_EN, A_SRST_N, B_EN, B_SRST_N, C_EN, C_SRST_N;
    logic               CDIN_FDBK_SEL, P_EN, P_SRST_N, IN_VALID;

    logic signed [39:0] p_def, p_add, p_acc, p_mr;
    logic               ov_def, ov_add, ov_acc, ov_mr;
    logic               ovf_def, ovf_add, ovf_acc, ovf_mr;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mae_behav_model u_def (
        .CLK(CLK), .ARST(ARST),
        .A(A), .A_EN(A_EN), .A_SRST_N(A_SRST_N),
        .B(B), .B_EN(B_EN), .B_SRST_N(B_SRST_N),
        .C(C), .C_EN(C_EN), .C_SRST_N(C_SRST_N),
        .CDIN_FDBK_SEL(CDIN_FDBK_SEL), .P_EN(P_EN), .P_SRST_N(P_SRST_N),
        .IN_VALID(IN_VALID), .P(p_def), .OUT_VALID(ov_def), .OVF(ovf_def)
    );

    mae_behav_model #(.REG_C(1), .POST_ADDER_STATIC(1)) u_add (
        .CLK(CLK), .ARST(ARST),
        .A(A), .A_EN(A_EN), .A_SRST_N(A_SRST_N),
        .B(B), .B_EN(B_EN), .B_SRST_N(B_SRST_N),
        .C(C), .C_EN(C_EN), .C_SRST_N(C_SRST_N),
        .CDIN_FDBK_SEL(CDIN_FDBK_SEL), .P_EN(P_EN), .P_SRST_N(P_SRST_N),
        .IN_VALID(IN_VALID), .P(p_add), .OUT_VALID(ov_add), .OVF(ovf_add)
    );

    mae_behav_model #(.POST_ADDER_STATIC(1), .USE_FEEDBACK(1)) u_acc (
        .CLK(CLK), .ARST(ARST),
        .A(A), .A_EN(A_EN), .A_SRST_N(A_SRST_N),
        .B(B), .B_EN(B_EN), .B_SRST_N(B_SRST_N),
        .C(C), .C_EN(C_EN), .C_SRST_N(C_SRST_N),
        .CDIN_FDBK_SEL(CDIN_FDBK_SEL), .P_EN(P_EN), .P_SRST_N(P_SRST_N),
        .IN_VALID(IN_VALID), .P(p_acc), .OUT_VALID(ov_acc), .OVF(ovf_acc)
    );

    mae_behav_model #(.MULT_HAS_REG(1)) u_mr (
        .CLK(CLK), .ARST(ARST),
        .A(A), .A_EN(A_EN), .A_SRST_N(A_SRST_N),
        .B(B), .B_EN(B_EN), .B_SRST_N(B_SRST_N),
        .C(C), .C_EN(C_EN), .C_SRST_N(C_SRST_N),
        .CDIN_FDBK_SEL(CDIN_FDBK_SEL), .P_EN(P_EN), .P_SRST_N(P_SRST_N),
        .IN_VALID(IN_VALID), .P(p_mr), .OUT_VALID(ov_mr), .OVF(ovf_mr)
    );

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        ARST = 1'b1;
        A = '0; B = '0; C = '0;
        A_EN = 1'b0; B_EN = 1'b0; C_EN = 1'b0; P_EN = 1'b0;
        A_SRST_N = 1'b1; B_SRST_N = 1'b1; C_SRST_N = 1'b1; P_SRST_N = 1'b1;
        CDIN_FDBK_SEL = 1'b0; IN_VALID = 1'b0;
        step(); step();
        checks++;
        if (p_def !== 40'h0 || p_acc !== 40'h0 || p_mr !== 40'h0 || p_add !== 40'h0) begin
            errors++;
            $display("FAIL reset_p def=%h add=%h acc=%h mr=%h expected 0", p_def, p_add, p_acc, p_mr);
        end
        checks++;
        if ({ov_def, ov_add, ov_acc, ov_mr, ovf_def, ovf_add, ovf_acc, ovf_mr} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got %b expected 00000000",
                     {ov_def, ov_add, ov_acc, ov_mr, ovf_def, ovf_add, ovf_acc, ovf_mr});
        end
        ARST = 1'b0;
        step();
    endtask

    task automatic test_mult_latency();
        A = -18'sd3; B = 18'sd7;
        A_EN = 1'b1; B_EN = 1'b1; P_EN = 1'b1; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        checks++;
        if (ov_def !== 1'b0) begin
            errors++;
            $display("FAIL valid_early got %b expected 0", ov_def);
        end
        step();
        checks++;
        if (p_def !== 40'hFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult_p got %h expected ffffffffeb", p_def);
        end
        checks++;
        if (ov_def !== 1'b1 || ov_mr !== 1'b0) begin
            errors++;
            $display("FAIL valid_l2 got def=%b mr=%b expected def=1 mr=0", ov_def, ov_mr);
        end
        step();
        checks++;
        if (ov_def !== 1'b0 || ov_mr !== 1'b1) begin
            errors++;
            $display("FAIL valid_l3 got def=%b mr=%b expected def=0 mr=1", ov_def, ov_mr);
        end
        checks++;
        if (p_mr !== 40'hFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult_reg_p got %h expected ffffffffeb", p_mr);
        end
    endtask

    task automatic test_corner();
        A = -18'sd131072; B = -18'sd131072;
        step(); step();
        checks++;
        if (p_def !== 40'h04_0000_0000 || ovf_def !== 1'b0) begin
            errors++;
            $display("FAIL corner_min got p=%h ovf=%b expected p=0400000000 ovf=0", p_def, ovf_def);
        end
    endtask

    task automatic test_post_adder();
        A = 18'sd100; B = 18'sd200; C = 40'sd1000; C_EN = 1'b1;
        step(); step();
        checks++;
        if (p_add !== 40'sd21000) begin
            errors++;
            $display("FAIL post_add got %0d expected 21000", p_add);
        end
        C_SRST_N = 1'b0;
        step();
        checks++;
        if (p_add !== 40'sd21000) begin
            errors++;
            $display("FAIL c_srst_same got %0d expected 21000", p_add);
        end
        C_SRST_N = 1'b1; C_EN = 1'b0;
        step();
        checks++;
        if (p_add !== 40'sd20000) begin
            errors++;
            $display("FAIL c_srst_next got %0d expected 20000", p_add);
        end
    endtask

    task automatic test_feedback();
        logic signed [39:0] exp_acc [4];
        exp_acc[0] = 40'sd11; exp_acc[1] = 40'sd17; exp_acc[2] = 40'sd23; exp_acc[3] = 40'sd29;
        A = 18'sd2; B = 18'sd3; C = 40'sd5; P_EN = 1'b0; CDIN_FDBK_SEL = 1'b0;
        step();
        P_EN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            CDIN_FDBK_SEL = 1'b1;
            checks++;
            if (p_acc !== exp_acc[i]) begin
                errors++;
                $display("FAIL accum_%0d got %0d expected %0d", i, p_acc, exp_acc[i]);
            end
        end
        P_EN = 1'b0;
        step();
        checks++;
        if (p_acc !== 40'sd29) begin
            errors++;
            $display("FAIL accum_hold got %0d expected 29", p_acc);
        end
        P_EN = 1'b1; P_SRST_N = 1'b0;
        step();
        checks++;
        if (p_acc !== 40'sd0) begin
            errors++;
            $display("FAIL accum_srst got %0d expected 0", p_acc);
        end
        P_SRST_N = 1'b1;
        step();
        checks++;
        if (p_acc !== 40'sd6) begin
            errors++;
            $display("FAIL accum_restart got %0d expected 6", p_acc);
        end
    endtask

    task automatic test_overflow();
        logic signed [39:0] exp_p;
        logic               exp_ovf;
`ifdef MAE_SATURATE_EN
        exp_p = 40'h7F_FFFF_FFFF; exp_ovf = 1'b1;
`else
        exp_p = 40'h80_0000_0030; exp_ovf = 1'b0;
`endif
        A = '0; B = '0; P_EN = 1'b0;
        step();
        C = 40'h7F_FFFF_FFF0; CDIN_FDBK_SEL = 1'b0; P_EN = 1'b1;
        step();
        checks++;
        if (p_acc !== 40'h7F_FFFF_FFF0) begin
            errors++;
            $display("FAIL ovf_preload got %h expected 7ffffffff0", p_acc);
        end
        A = 18'sd8; B = 18'sd8; P_EN = 1'b0;
        step();
        CDIN_FDBK_SEL = 1'b1; P_EN = 1'b1;
        step();
        checks++;
        if (p_acc !== exp_p || ovf_acc !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_edge got p=%h ovf=%b expected p=%h ovf=%b", p_acc, ovf_acc, exp_p, exp_ovf);
        end
        P_EN = 1'b0;
        step();
        checks++;
        if (ovf_acc !== 1'b0 || p_acc !== exp_p) begin
            errors++;
            $display("FAIL ovf_pulse got p=%h ovf=%b expected p=%h ovf=0", p_acc, ovf_acc, exp_p);
        end
    endtask

    task automatic test_async_reset();
        A = 18'sd1; B = 18'sd1; C = '0; P_EN = 1'b0; IN_VALID = 1'b1;
        step();
        CDIN_FDBK_SEL = 1'b0; P_EN = 1'b1;
        step();
        CDIN_FDBK_SEL = 1'b1;
        step();
        checks++;
        if (p_acc !== 40'sd2 || ov_acc !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got p=%0d vld=%b expected p=2 vld=1", p_acc, ov_acc);
        end
        // Pulse ARST between clock edges.
        IN_VALID = 1'b0;
        #2 ARST = 1'b1;
        #1;
        checks++;
        if (p_acc !== 40'sd0 || ov_acc !== 1'b0 || ovf_acc !== 1'b0 || p_def !== 40'sd0) begin
            errors++;
            $display("FAIL arst_now got p=%0d vld=%b ovf=%b def=%0d expected 0", p_acc, ov_acc, ovf_acc, p_def);
        end
        #1 ARST = 1'b0;
        A = 18'sd4; B = 18'sd5; P_EN = 1'b0;
        step();
        P_EN = 1'b1;
        step();
        checks++;
        if (p_acc !== 40'sd20) begin
            errors++;
            $display("FAIL arst_resume got %0d expected 20", p_acc);
        end
    endtask

    initial begin
        test_reset();
        test_mult_latency();
        test_corner();
        test_post_adder();
        test_feedback();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
